// File: rtl/icache_mem_responder.sv
// Instruction-cache fill responder: round-robin arbitration of CPU fetches onto one RAM port.
// Optional macro IMEM_ERR_RETRY_EN adds a RETRY state with a bounded ERROR retry count.
module icache_mem_responder #(
    parameter int unsigned CPUS   = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS*DATA_W-1:0]   iload,
    output logic                     ramREN,
    output logic [ADDR_W-1:0]        ramaddr,
    input  logic [DATA_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int unsigned GW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RamAccess = 2'd2;

`ifdef IMEM_ERR_RETRY_EN
    localparam logic [1:0] RamError = 2'd3;
    typedef enum logic [1:0] {StIdle, StReq, StRetry} state_e;
    logic [1:0] errcnt_q, errcnt_d;
`else
    typedef enum logic [1:0] {StIdle, StReq} state_e;
`endif

    state_e              state_q, state_d;
    logic [GW-1:0]       gnt_q, gnt_d;
    logic [GW-1:0]       rr_q, rr_d;
    logic [GW-1:0]       rr_next;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                bubble_q, bubble_d;

    logic                cur_ren;
    logic [ADDR_W-1:0]   cur_addr;
    logic                hit;
    logic                resp;
    logic                err_resp;
    logic                release_gnt;

    // Request lines of the CPU currently holding the grant.
    always_comb begin
        cur_ren  = 1'b0;
        cur_addr = '0;
        for (int i = 0; i < CPUS; i++) begin
            if (gnt_q == GW'(i)) begin
                cur_ren  = iREN[i];
                cur_addr = iaddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign hit     = cur_ren && (cur_addr == addr_q);
    assign rr_next = (gnt_q == GW'(CPUS - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin : p_next
        int unsigned idx;
        logic        found;
        idx         = 0;
        found       = 1'b0;
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        addr_d      = addr_q;
        bubble_d    = 1'b0;
        resp        = 1'b0;
        err_resp    = 1'b0;
        release_gnt = 1'b0;
`ifdef IMEM_ERR_RETRY_EN
        errcnt_d    = errcnt_q;
`endif
        case (state_q)
            StIdle: begin
                // bubble_q holds off arbitration for the one cycle after a release
                if (!bubble_q) begin
                    for (int unsigned k = 0; k < CPUS; k++) begin
                        idx = (32'(rr_q) + k) % CPUS;
                        if (!found && iREN[idx]) begin
                            found   = 1'b1;
                            gnt_d   = GW'(idx);
                            addr_d  = iaddr[idx*ADDR_W +: ADDR_W];
                            state_d = StReq;
                        end
                    end
                end
            end
            StReq: begin
                if (!hit) begin
                    release_gnt = 1'b1;
                end else if (ramstate == RamAccess) begin
                    resp        = !RST;
                    release_gnt = 1'b1;
`ifdef IMEM_ERR_RETRY_EN
                end else if (ramstate == RamError) begin
                    if (errcnt_q == 2'd2) begin
                        resp        = !RST;
                        err_resp    = !RST;
                        release_gnt = 1'b1;
                    end else begin
                        errcnt_d = errcnt_q + 2'd1;
                        state_d  = StRetry;
                    end
`endif
                end
            end
`ifdef IMEM_ERR_RETRY_EN
            StRetry: begin
                if (!hit) release_gnt = 1'b1;
                else      state_d     = StReq;
            end
`endif
            default: state_d = StIdle;
        endcase

        if (release_gnt) begin
            state_d  = StIdle;
            rr_d     = rr_next;
            bubble_d = 1'b1;
`ifdef IMEM_ERR_RETRY_EN
            errcnt_d = '0;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            rr_q     <= '0;
            addr_q   <= '0;
            bubble_q <= 1'b0;
`ifdef IMEM_ERR_RETRY_EN
            errcnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            bubble_q <= bubble_d;
`ifdef IMEM_ERR_RETRY_EN
            errcnt_q <= errcnt_d;
`endif
        end
    end

    always_comb begin
        iwait = '1;
        for (int i = 0; i < CPUS; i++) begin
            if (resp && (gnt_q == GW'(i))) iwait[i] = 1'b0;
        end
    end

    assign iload   = err_resp ? '0 : {CPUS{ramload}};
    assign ramREN  = (state_q == StReq);
    assign ramaddr = addr_q;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Directed plus randomized bench for icache_mem_responder (CPUS=2) against a cycle-level model.
module tb_icache_mem_responder;

    localparam int CPUS = 2;
`ifdef IMEM_ERR_RETRY_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic [1:0]  iREN;
    logic [63:0] iaddr;
    logic [1:0]  iwait;
    logic [63:0] iload;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    icache_mem_responder #(.CPUS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .ramREN   (ramREN),
        .ramaddr  (ramaddr),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = fetch outstanding at RAM, 2 = retry gap after ERROR
    int          m_state, m_gnt, m_rr, m_err;
    bit          m_bubble;
    logic [31:0] m_addr;

    logic [1:0]  last_iwait;
    logic        last_ren;
    logic [31:0] last_addr;
    logic [63:0] last_load;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_gnt = 0; m_rr = 0; m_err = 0; m_bubble = 0; m_addr = '0;
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic step();
        bit          hit, resp, err_resp, rel;
        logic [1:0]  exp_iwait;
        #1;
        hit      = iREN[m_gnt] && (iaddr[m_gnt*32 +: 32] == m_addr);
        err_resp = ErrEn && !RST && m_state == 1 && hit && ramstate == 2'd3 && m_err == 2;
        resp     = (!RST && m_state == 1 && hit && ramstate == 2'd2) || err_resp;
        exp_iwait = 2'b11;
        if (resp) exp_iwait[m_gnt] = 1'b0;
        chk("iwait", iwait, exp_iwait);
        chk("ramREN", ramREN, m_state == 1);
        chk("ramaddr", ramaddr, m_addr);
        chk("iload", iload, err_resp ? 64'd0 : {ramload, ramload});
        last_iwait = iwait; last_ren = ramREN; last_addr = ramaddr; last_load = iload;
        @(posedge CLK);
        rel = 0;
        if (RST) begin
            m_reset();
        end else if (m_state == 0) begin
            if (!m_bubble) begin
                for (int k = 0; k < CPUS; k++) begin
                    int idx;
                    idx = (m_rr + k) % CPUS;
                    if (m_state == 0 && iREN[idx]) begin
                        m_gnt = idx; m_addr = iaddr[idx*32 +: 32]; m_state = 1;
                    end
                end
            end
            m_bubble = 0;
        end else if (m_state == 1) begin
            if (!hit || resp) rel = 1;
            else if (ErrEn && ramstate == 2'd3) begin m_err++; m_state = 2; end
        end else begin
            if (!hit) rel = 1;
            else m_state = 1;
        end
        if (rel) begin
            m_state = 0; m_rr = (m_gnt + 1) % CPUS; m_bubble = 1; m_err = 0;
        end
        @(negedge CLK);
    endtask

    int pc[$];
    int pg[$];
    int fetch_cyc;
    bit seen;
    logic [0:4] err_pat;

    initial begin
        RST = 1'b1; iREN = '0; iaddr = '0; ramload = '0; ramstate = 2'd0;
        m_reset();
        @(posedge CLK); @(posedge CLK); @(negedge CLK);

        // Reset values while RST is held
        step();
        chk("rst_iwait", last_iwait, 2'b11);
        chk("rst_ren", last_ren, 1'b0);
        chk("rst_addr", last_addr, 32'h0);
        RST = 1'b0;

        // Single fetch: BUSY, BUSY, ACCESS
        iREN = 2'b01; iaddr[31:0] = 32'h40; ramstate = 2'd1; ramload = 32'h2108_0004;
        step();
        chk("fetch_c0_ren", last_ren, 1'b0);
        seen = 0; fetch_cyc = -1;
        for (int c = 1; c <= 3; c++) begin
            ramstate = (c == 3) ? 2'd2 : 2'd1;
            step();
            chk("fetch_ren", last_ren, 1'b1);
            chk("fetch_addr", last_addr, 32'h40);
            chk("fetch_iwait1", last_iwait[1], 1'b1);
            if (last_iwait[0] == 1'b0) fetch_cyc = c;
        end
        chk("fetch_pulse_cycle", fetch_cyc, 3);
        chk("fetch_load", last_load[31:0], 32'h2108_0004);
        iREN = 2'b00; ramstate = 2'd0;
        step();
        chk("fetch_after", last_iwait, 2'b11);

        // Contention with zero-wait RAM
        iREN = 2'b11; iaddr = {32'h200, 32'h100}; ramstate = 2'd2;
        for (int c = 0; c < 12; c++) begin
            step();
            if (last_iwait != 2'b11) begin
                pc.push_back(c);
                pg.push_back(last_iwait == 2'b10 ? 0 : 1);
            end
        end
        chk("cont_count", pc.size(), 4);
        if (pg.size() > 0) chk("cont_first", pg[0], 1);
        for (int j = 1; j < pc.size(); j++) begin
            chk("cont_spacing", pc[j] - pc[j-1], 3);
            chk("cont_alternate", pg[j], 1 - pg[j-1]);
        end
        iREN = 2'b00;
        repeat (3) step();

        // Abort: CPU1 address changes while RAM is BUSY
        iREN = 2'b10; iaddr[63:32] = 32'h80; ramstate = 2'd1;
        step();
        step();
        chk("abort_req_addr", last_addr, 32'h80);
        iaddr[63:32] = 32'h84;
        step();
        chk("abort_no_pulse", last_iwait, 2'b11);
        step();
        chk("abort_bubble_ren", last_ren, 1'b0);
        step();
        ramstate = 2'd2;
        step();
        chk("abort_relatch", last_addr, 32'h84);
        chk("abort_serve", last_iwait, 2'b01);
        iREN = 2'b00;
        step();

        // Reset mid-request: move rr to 1 first so the reset is observable
        iREN = 2'b01; iaddr[31:0] = 32'h40; ramstate = 2'd2;
        step(); step();
        iREN = 2'b00; step();
        iREN = 2'b10; iaddr[63:32] = 32'h200; ramstate = 2'd1;
        step(); step();
        chk("rst_mid_inreq", last_ren, 1'b1);
        ramstate = 2'd2; RST = 1'b1;
        step();
        chk("rst_mid_nopulse", last_iwait, 2'b11);
        RST = 1'b0; iREN = 2'b11;
        step();
        chk("rst_mid_ren", last_ren, 1'b0);
        chk("rst_mid_iwait", last_iwait, 2'b11);
        step();
        chk("rst_rr_zero", last_addr, 32'h40);
        iREN = 2'b00; ramstate = 2'd0;
        step();

        // ERROR responses from RAM
        iREN = 2'b01; iaddr[31:0] = 32'h44; ramstate = 2'd3; ramload = 32'hdead_beef;
        step();
        err_pat = ErrEn ? 5'b10101 : 5'b11111;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("err_ren", last_ren, err_pat[c]);
            if (c < 4) chk("err_nopulse", last_iwait, 2'b11);
        end
        if (ErrEn) begin
            chk("err_pulse", last_iwait, 2'b10);
            chk("err_load", last_load, 64'd0);
        end else begin
            chk("err_hold", last_iwait, 2'b11);
            ramstate = 2'd2;
            step();
            chk("err_access", last_iwait, 2'b10);
        end
        iREN = 2'b00; ramstate = 2'd0;
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            RST = ($urandom_range(63) == 0);
            for (int i = 0; i < CPUS; i++) begin
                if ($urandom_range(7) == 0) iREN[i] = ~iREN[i];
                if ($urandom_range(15) == 0) iaddr[i*32 +: 32] = 32'h40 + 4 * $urandom_range(15);
            end
            ramstate = 2'($urandom_range(3));
            ramload  = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
